// File: rtl/l2_cache_nway_if.sv
// Request/response and downstream memory port bundle for l2_cache_nway.
// The cache connects through the slave modport; the requester/memory side uses master.
interface l2_cache_nway_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  // Valid/ready: a transfer happens on the rising edge where both are high; while valid
  // is high and ready is low the sender keeps valid asserted and the payload unchanged.
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [BE_W-1:0]       req_be_i;
  logic                  resp_valid_o;
  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  resp_hit_o;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_resp_valid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_hit_o,
    output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_hit_o,
    input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 with multi-word lines.
// One request in flight; misses write back a dirty victim and refill one word per beat.
module l2_cache_nway #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 256,
  parameter int NUM_WAYS       = 4
) (
  input  logic                clk,
  input  logic                rst,
  l2_cache_nway_if.slave      bus,
  output logic [2:0]          dbg_state_o
);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFF_W  = (BE_W > 1) ? $clog2(BE_W) : 1;
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - WORD_W - OFF_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WB        = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_WAIT = 3'd4,
    S_RESP      = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_W-1:0]     beat_q, beat_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic                  hit_q, hit_d;

  logic [TAG_W-1:0]      req_tag_q;
  logic [IDX_W-1:0]      idx_q;
  logic [WORD_W-1:0]     word_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]       be_q;

  logic [DATA_WIDTH-1:0] data_q    [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
  logic [TAG_W-1:0]      tag_mem_q [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_q   [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q   [NUM_SETS];
  logic [WAY_W-1:0]      age_q     [NUM_SETS][NUM_WAYS];

  logic                  req_fire;
  logic                  hit_any;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      victim;
  logic                  fill_last;
  logic                  age_touch;
  logic [WAY_W-1:0]      acc_way;
  logic [WAY_W-1:0]      old_age;
  logic [WAY_W-1:0]      age_next  [NUM_WAYS];
  logic                  dwe;
  logic [WAY_W-1:0]      dway;
  logic [WORD_W-1:0]     dword;
  logic [DATA_WIDTH-1:0] dwdata;
  logic                  unused_byte_off;

  // The byte-offset field of the request address plays no part in the lookup.
  assign unused_byte_off = ^bus.req_addr_i[OFF_W-1:0];
  assign dbg_state_o     = state_q;
  assign req_fire        = bus.req_valid_i && (state_q == S_IDLE);
  assign fill_last       = (state_q == S_FILL_WAIT) && bus.mem_resp_valid_i &&
                           (beat_q == WORD_W'(WORDS_PER_LINE - 1));
  assign age_touch       = ((state_q == S_LOOKUP) && hit_any) || fill_last;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_W-1:0]       be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // Tag compare and victim choice: lowest invalid way wins, otherwise the age-0 way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx_q][w] && (tag_mem_q[idx_q][w] == req_tag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (age_q[idx_q][w] == '0) victim = WAY_W'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_q][w]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    acc_way = (state_q == S_LOOKUP) ? hit_way : way_q;
    old_age = age_q[idx_q][acc_way];
    for (int w = 0; w < NUM_WAYS; w++) begin
      age_next[w] = age_q[idx_q][w];
      if (WAY_W'(w) == acc_way) begin
        age_next[w] = WAY_W'(NUM_WAYS - 1);
      end else if (age_q[idx_q][w] > old_age) begin
        age_next[w] = age_q[idx_q][w] - WAY_W'(1);
      end
    end
  end

  // Single data write port: a write hit, or a refill beat with any pending write merged in.
  always_comb begin
    dwe    = 1'b0;
    dway   = way_q;
    dword  = word_q;
    dwdata = '0;
    if ((state_q == S_LOOKUP) && hit_any && we_q) begin
      dwe    = 1'b1;
      dway   = hit_way;
      dwdata = merge_bytes(data_q[idx_q][hit_way][word_q], wdata_q, be_q);
    end else if ((state_q == S_FILL_WAIT) && bus.mem_resp_valid_i) begin
      dwe    = 1'b1;
      dword  = beat_q;
      dwdata = (we_q && (beat_q == word_q)) ?
               merge_bytes(bus.mem_rdata_i, wdata_q, be_q) : bus.mem_rdata_i;
    end
  end

  always_comb begin
    state_d              = state_q;
    beat_d               = beat_q;
    way_d                = way_q;
    hit_d                = hit_q;
    bus.req_ready_o      = 1'b0;
    bus.resp_valid_o     = 1'b0;
    bus.resp_rdata_o     = '0;
    bus.resp_hit_o       = 1'b0;
    bus.mem_req_valid_o  = 1'b0;
    bus.mem_we_o         = 1'b0;
    bus.mem_addr_o       = '0;
    bus.mem_wdata_o      = '0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        beat_d = '0;
        hit_d  = hit_any;
        if (hit_any) begin
          way_d   = hit_way;
          state_d = S_RESP;
        end else begin
          way_d   = victim;
          state_d = (valid_q[idx_q][victim] && dirty_q[idx_q][victim]) ? S_WB : S_FILL_REQ;
        end
      end
      S_WB: begin
        // Payload depends only on registered state, so it holds across a stall.
        bus.mem_req_valid_o = 1'b1;
        bus.mem_we_o        = 1'b1;
        bus.mem_addr_o      = {tag_mem_q[idx_q][way_q], idx_q, beat_q, {OFF_W{1'b0}}};
        bus.mem_wdata_o     = data_q[idx_q][way_q][beat_q];
        if (bus.mem_req_ready_i) begin
          beat_d = beat_q + WORD_W'(1);
          if (beat_q == WORD_W'(WORDS_PER_LINE - 1)) state_d = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        bus.mem_req_valid_o = 1'b1;
        bus.mem_addr_o      = {req_tag_q, idx_q, beat_q, {OFF_W{1'b0}}};
        if (bus.mem_req_ready_i) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (bus.mem_resp_valid_i) begin
          beat_d  = beat_q + WORD_W'(1);
          state_d = fill_last ? S_RESP : S_FILL_REQ;
        end
      end
      S_RESP: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_hit_o   = hit_q;
        bus.resp_rdata_o = we_q ? '0 : data_q[idx_q][way_q][word_q];
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      way_q     <= '0;
      hit_q     <= 1'b0;
      req_tag_q <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      if (req_fire) begin
        {req_tag_q, idx_q, word_q} <= bus.req_addr_i[ADDR_WIDTH-1:OFF_W];
        we_q    <= bus.req_we_i;
        wdata_q <= bus.req_wdata_i;
        be_q    <= bus.req_be_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (age_touch) begin
        for (int w = 0; w < NUM_WAYS; w++) age_q[idx_q][w] <= age_next[w];
      end
      if ((state_q == S_LOOKUP) && hit_any && we_q) dirty_q[idx_q][hit_way] <= 1'b1;
      if (fill_last) begin
        valid_q[idx_q][way_q] <= 1'b1;
        dirty_q[idx_q][way_q] <= we_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dwe && !rst) data_q[idx_q][dway][dword] <= dwdata;
    if (fill_last && !rst) tag_mem_q[idx_q][way_q] <= req_tag_q;
  end
endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed bench for l2_cache_nway: vector table plus hand-written miss/writeback/reset sequences.
module tb_l2_cache_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;
  int checks   = 0;
  int failures = 0;

  l2_cache_nway_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  l2_cache_nway dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  beat_t       beat_log [$];
  vec_t        vecs [$];
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] wb_exp [4];

  logic        hold_resp    = 1'b0;
  logic        resp_pending = 1'b0;
  logic [31:0] resp_addr    = '0;
  int          stall_left   = 0;
  int          stall_obs    = 0;
  logic        was_stalled  = 1'b0;
  logic [31:0] held_addr, held_data;
  logic        held_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return 32'hA500_0000 | a;
  endfunction

  // Memory model: decisions made at negedge apply to the following rising edge.
  initial begin
    bus.mem_req_ready_i  = 1'b1;
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_rdata_i      = '0;
    forever begin
      @(negedge clk);
      if (!hold_resp) begin
        if (resp_pending) begin
          bus.mem_resp_valid_i = 1'b1;
          bus.mem_rdata_i      = mem_read(resp_addr);
          resp_pending         = 1'b0;
        end else begin
          bus.mem_resp_valid_i = 1'b0;
          bus.mem_rdata_i      = '0;
        end
      end
      if (was_stalled) begin
        check("stall_hold_addr", bus.mem_addr_o, held_addr);
        check("stall_hold_wdata", bus.mem_wdata_o, held_data);
        check("stall_hold_we", {31'd0, bus.mem_we_o}, {31'd0, held_we});
      end
      if (bus.mem_req_valid_o && bus.mem_we_o && stall_left > 0) begin
        bus.mem_req_ready_i = 1'b0;
        stall_left--;
      end else begin
        bus.mem_req_ready_i = 1'b1;
      end
      was_stalled = bus.mem_req_valid_o && !bus.mem_req_ready_i;
      if (was_stalled) begin
        stall_obs++;
        held_addr = bus.mem_addr_o;
        held_data = bus.mem_wdata_o;
        held_we   = bus.mem_we_o;
      end
      if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
        beat_log.push_back('{bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o});
        if (bus.mem_we_o) begin
          mem_store[bus.mem_addr_o] = bus.mem_wdata_o;
        end else if (!hold_resp) begin
          resp_pending = 1'b1;
          resp_addr    = bus.mem_addr_o;
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic hit,
                        output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_be_i    = be;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.resp_valid_o && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid_o) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout addr=0x%08h actual=no_response expected=resp_valid", addr);
    end
    rdata = bus.resp_rdata_o;
    hit   = bus.resp_hit_o;
  endtask

  initial begin
    logic [31:0] rd;
    logic        hit;
    int          lat;
    int          base;
    int          nwr;
    int          guard;

    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_be_i    = '0;
    mem_store[32'h1000] = 32'hDEADBEEF;
    mem_store[32'h1008] = 32'hAABBCCDD;
    wb_exp[0] = 32'hCAFEF00D;
    wb_exp[1] = 32'hA500_1004;
    wb_exp[2] = 32'hAABB3344;
    wb_exp[3] = 32'hA500_100C;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    check("rst_resp_hit", {31'd0, bus.resp_hit_o}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata_o, 32'd0);
    check("rst_mem_valid", {31'd0, bus.mem_req_valid_o}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    // Cold miss: four refill reads in beat order, first word returned as read data.
    base = beat_log.size();
    do_req(1'b0, 32'h1000, '0, '0, rd, hit, lat);
    check("miss_rdata", rd, 32'hDEADBEEF);
    check("miss_hit", {31'd0, hit}, 32'd0);
    check("miss_beats", beat_log.size() - base, 32'd4);
    for (int i = 0; i < 4 && base + i < beat_log.size(); i++) begin
      check($sformatf("miss_beat%0d_addr", i), beat_log[base+i].addr, 32'h1000 + 32'(4*i));
      check($sformatf("miss_beat%0d_we", i), {31'd0, beat_log[base+i].we}, 32'd0);
    end

    base = beat_log.size();
    do_req(1'b0, 32'h1004, '0, '0, rd, hit, lat);
    check("hit_rdata", rd, 32'hA500_1004);
    check("hit_hit", {31'd0, hit}, 32'd1);
    check("hit_latency", 32'(lat), 32'd2);
    check("hit_no_mem", beat_log.size() - base, 32'd0);
    @(negedge clk);
    check("resp_one_cycle", {31'd0, bus.resp_valid_o}, 32'd0);

    vecs.push_back('{1'b0, 32'h1010, 32'h0,        4'h0,    32'hA500_1010, 1'b0});
    vecs.push_back('{1'b0, 32'h1014, 32'h0,        4'h0,    32'hA500_1014, 1'b1});
    vecs.push_back('{1'b1, 32'h1008, 32'h11223344, 4'b0011, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h1008, 32'h0,        4'h0,    32'hAABB3344,  1'b1});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'h0,    32'hDEADBEEF,  1'b1});
    vecs.push_back('{1'b0, 32'h2000, 32'h0,        4'h0,    32'hA500_2000, 1'b0});
    vecs.push_back('{1'b0, 32'h3000, 32'h0,        4'h0,    32'hA500_3000, 1'b0});
    vecs.push_back('{1'b0, 32'h4000, 32'h0,        4'h0,    32'hA500_4000, 1'b0});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'h0,    32'hDEADBEEF,  1'b1});
    vecs.push_back('{1'b0, 32'h5000, 32'h0,        4'h0,    32'hA500_5000, 1'b0});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'h0,    32'hDEADBEEF,  1'b1});
    vecs.push_back('{1'b0, 32'h2000, 32'h0,        4'h0,    32'hA500_2000, 1'b0});
    vecs.push_back('{1'b1, 32'h1000, 32'hCAFEF00D, 4'b1111, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h6000, 32'h0,        4'h0,    32'hA500_6000, 1'b0});
    vecs.push_back('{1'b0, 32'h7000, 32'h0,        4'h0,    32'hA500_7000, 1'b0});
    vecs.push_back('{1'b0, 32'h8000, 32'h0,        4'h0,    32'hA500_8000, 1'b0});
    for (int v = 0; v < vecs.size(); v++) begin
      do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, rd, hit, lat);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("vec%0d_hit", v), {31'd0, hit}, {31'd0, vecs[v].exp_hit});
    end

    // Dirty 0x1000 line is the age-0 victim: writeback (with a 3-cycle stall) before refill.
    base       = beat_log.size();
    stall_obs  = 0;
    stall_left = 3;
    do_req(1'b0, 32'h9000, '0, '0, rd, hit, lat);
    check("wb_miss_rdata", rd, 32'hA500_9000);
    check("wb_miss_hit", {31'd0, hit}, 32'd0);
    check("wb_total_beats", beat_log.size() - base, 32'd8);
    check("wb_stall_cycles", 32'(stall_obs), 32'd3);
    nwr = 0;
    for (int i = base; i < beat_log.size(); i++) if (beat_log[i].we) nwr++;
    check("wb_write_beats", 32'(nwr), 32'd4);
    for (int i = 0; i < 8 && base + i < beat_log.size(); i++) begin
      if (i < 4) begin
        check($sformatf("wb%0d_we", i), {31'd0, beat_log[base+i].we}, 32'd1);
        check($sformatf("wb%0d_addr", i), beat_log[base+i].addr, 32'h1000 + 32'(4*i));
        check($sformatf("wb%0d_data", i), beat_log[base+i].data, wb_exp[i]);
      end else begin
        check($sformatf("fill%0d_we", i), {31'd0, beat_log[base+i].we}, 32'd0);
        check($sformatf("fill%0d_addr", i), beat_log[base+i].addr, 32'h9000 + 32'(4*(i-4)));
      end
    end
    do_req(1'b0, 32'h1008, '0, '0, rd, hit, lat);
    check("wb_readback_rdata", rd, 32'hAABB3344);
    check("wb_readback_hit", {31'd0, hit}, 32'd0);

    // Reset while waiting for refill data; a late response must not disturb anything.
    hold_resp = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'hA000;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    guard = 0;
    while (!(bus.mem_req_valid_o && !bus.mem_we_o && bus.mem_req_ready_i) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rst_seq_read_beat_seen", {31'd0, bus.mem_req_valid_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("midrst_mem_valid", {31'd0, bus.mem_req_valid_o}, 32'd0);
    check("midrst_mem_addr", bus.mem_addr_o, 32'd0);
    rst = 1'b0;
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_rdata_i      = 32'hBAD0BAD0;
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_rdata_i      = '0;
    check("stray_state", {29'd0, dbg_state}, 32'd0);
    check("stray_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    check("stray_mem_valid", {31'd0, bus.mem_req_valid_o}, 32'd0);
    hold_resp    = 1'b0;
    resp_pending = 1'b0;
    do_req(1'b0, 32'h1000, '0, '0, rd, hit, lat);
    check("post_rst_rdata", rd, 32'hCAFEF00D);
    check("post_rst_hit", {31'd0, hit}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
